// File: rtl/next_pc_unit.sv
// Program counter and next-PC generator for the MIPS-style datapath. It handles
// branch, jump, jal, jr and return selection, stalls, and a circular return-address stack.
module next_pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               USE_RAS   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [25:0]      inst_index,
    input  logic             pc_src,
    input  logic             jmp,
    input  logic             jal,
    input  logic             jr,
    input  logic             ret,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] link_addr,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [15:0]      ras_mispredict_cnt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      mis_q, mis_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [PTR_W-1:0] ptr_inc, ptr_dec;
    logic [WIDTH-1:0] branch_tgt, jump_tgt, ras_top;
    logic             push_en;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + WIDTH'(4);
    assign link_addr = pc_plus4;

    assign ras_empty          = (cnt_q == '0);
    assign ras_full           = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_mispredict_cnt = mis_q;

    // The pointer names the next free slot; the top of stack sits one below it.
    assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
    assign ras_top = ras_q[ptr_dec];

    assign branch_tgt = pc_plus4 + {{(WIDTH-18){inst_index[15]}}, inst_index[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4[WIDTH-1:28], inst_index, 2'b00};

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        push_en = 1'b0;
        if (!stall) begin
            if (jr) begin
                pc_d = jr_target;
                if (ret && !ras_empty) begin
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (ras_top != jr_target)
                        mis_d = sat_inc(mis_q);
                    if (USE_RAS != 0)
                        pc_d = ras_top;
                end
            end else if (jmp || jal) begin
                pc_d = jump_tgt;
                if (jal) begin
                    // A push when full overwrites the oldest entry, count saturates.
                    push_en = 1'b1;
                    ptr_d   = ptr_inc;
                    if (!ras_full)
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (pc_src) begin
                pc_d = branch_tgt;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            mis_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en)
            ras_q[ptr_q] <= link_addr;
    end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Parametrised program-counter and next-PC generator for the MIPS-style datapath; replaces the fixed PC register, the PC+4 adder, the branch adder and the jump/JR/JAL selection chain.
- Adds pipeline stall support and a circular return-address stack (RAS) of configurable depth.
- In RAS mode, predicted returns come from the RAS. A saturating counter records every return whose RAS prediction differs from the register target.
- Sits between the controller/register file and instruction memory.

Parameters:
- WIDTH, 32, address/PC width; must be ≥ 32.
- RAS_DEPTH, 4, number of RAS entries; must be ≥ 2.
- RESET_PC, 0, PC value loaded on reset.
- USE_RAS, 0, 0 = JR target comes from jr_target; 1 = return target comes from the RAS top when the RAS is non-empty.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  1 = hold PC and RAS this cycle
- inst_index  input  26  instruction bits [25:0]; jump index, and [15:0] is the branch immediate
- pc_src  input  1  conditional branch taken
- jmp  input  1  J-type jump
- jal  input  1  jump-and-link; pushes the link address onto the RAS
- jr  input  1  jump-register
- ret  input  1  qualifies jr as a return (rs == 31); ignored when jr = 0
- jr_target  input  WIDTH  register-file read data 1
- pc  output  WIDTH  current PC, used as the instruction address
- pc_plus4  output  WIDTH  pc + 4, combinational
- link_addr  output  WIDTH  equals pc_plus4; register write data for jal
- ras_empty  output  1  RAS holds 0 entries
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_mispredict_cnt  output  16  count of return mispredictions

Behaviour:
- All state updates occur on the rising edge of clk. rst has priority over every other input.
- Reset:
  - pc = RESET_PC, RAS count = 0, RAS pointer = 0, ras_mispredict_cnt = 0.
  - ras_empty = 1, ras_full = 0.
  - RAS entry contents are don't-care.
  - Reset asserted mid-operation discards any in-flight push or pop.
- Arithmetic (all results wrap modulo 2^WIDTH):
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + (sign-extend(inst_index[15:0]) << 2).
  - Jump target = {pc_plus4[WIDTH-1:28], inst_index, 2'b00}.
- Next-PC priority when not stalled (highest first):
  1. jr: target = RAS top if USE_RAS = 1, ret = 1 and RAS is non-empty; otherwise jr_target.
  2. jmp or jal: jump target.
  3. pc_src: branch target.
  4. Otherwise: pc_plus4.
- Simultaneous control inputs resolve by the priority above. Any push or pop happens only if its instruction wins the priority selection.
- Stall:
  - pc, RAS and counter all hold.
  - jal, jr, ret and pc_src are ignored for that cycle.
  - Outputs stay stable; the RAS is not double-pushed across a stall.
- RAS push (jal wins, not stalled):
  - Write link_addr at the pointer, pointer advances modulo RAS_DEPTH, count = min(count + 1, RAS_DEPTH).
  - Push when full overwrites the oldest entry; ras_full stays 1.
- RAS pop (jr & ret wins, not stalled, RAS non-empty):
  - Pointer retreats modulo RAS_DEPTH; count decrements.
  - Pop when empty: no state change, target = jr_target, counter unchanged.
- Misprediction:
  - Applies on a non-stalled pop with a non-empty RAS. If RAS top ≠ jr_target, ras_mispredict_cnt increments, saturating at 16'hFFFF.
  - Counts in both USE_RAS modes. In mode 1 the PC still follows the RAS top; the controller owns recovery.
- jr with ret = 0 never touches the RAS.
- Latency:
  - Registered next PC appears on pc one cycle after the controls are sampled.
  - ras_empty, ras_full and the counter are registered and update on the same edge.

Test Plan:
- Reset, then 3 idle cycles -> pc = 0, 4, 8, 12. Assert rst mid-run at pc = 12 -> next pc = 0, ras_empty = 1, ras_mispredict_cnt = 0.
- Branch: pc = 0x40, pc_src = 1, imm = 0xFFFE -> pc = 0x3C. Same with imm = 0x0003 -> pc = 0x50.
- jal then return:
  - pc = 0x100, jal, inst_index = 0x000040 -> pc = 0x100, RAS top = 0x104, ras_empty = 0.
  - Then jr & ret with jr_target = 0x104 -> pc = 0x104, ras_empty = 1, counter = 0.
- Overflow/underflow, RAS_DEPTH = 4:
  - 5 jal pushes -> ras_full = 1; the first link address is lost.
  - 5 ret pops -> the 4 newest link addresses return in LIFO order; 5th pop uses jr_target, counter unchanged.
- USE_RAS = 1, RAS top = 0x200, ret with jr_target = 0x300 -> pc = 0x200, counter = 1. Same case with USE_RAS = 0 -> pc = 0x300, counter = 1.
- Stall and priority:
  - jal held with stall = 1 for 3 cycles -> pc frozen, RAS count unchanged; on stall release, exactly one push.
  - jr, jmp and pc_src together -> jr wins.
